// File: rtl/hazard_stall_controller.sv
// RAW hazard stall controller: detects IF/ID source conflicts against downstream writers,
// tracks stall episodes with a watchdog. Define HAZARD_PERF_CNT_EN to build the performance counters.
module hazard_stall_controller #(
   parameter int unsigned ADDR_W     = 5,
   parameter int unsigned NUM_STAGES = 3,
   parameter int unsigned MAX_STALL  = 8,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         instrValid_IfId,
   input  logic                         usesRs_IfId,
   input  logic                         usesRt_IfId,
   input  logic [ADDR_W-1:0]            rsAddress_IfId,
   input  logic [ADDR_W-1:0]            rtAddress_IfId,
   input  logic [NUM_STAGES-1:0]        regWrite_Stage,
   input  logic [NUM_STAGES*ADDR_W-1:0] rdAddress_Stage,
   input  logic                         flush,
   output logic                         stall,
   output logic                         bubble,
   output logic                         hazardRs,
   output logic                         hazardRt,
   output logic [NUM_STAGES-1:0]        hazardStage,
   output logic                         stallActive,
   output logic                         timeoutErr,
   output logic [CNT_W-1:0]             stallCycles,
   output logic [CNT_W-1:0]             hazardEvents
);

   typedef enum logic {RUN, STALL} state_t;

   state_t                state_q, state_d;
   logic [7:0]            episode_cnt_q, episode_cnt_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [7:0]            episode_inc;
   logic [NUM_STAGES-1:0] match_rs, match_rt;
   logic                  found;
   logic [ADDR_W-1:0]     rd;

   always_comb begin
      match_rs    = '0;
      match_rt    = '0;
      hazardStage = '0;
      found       = 1'b0;
      rd          = '0;
      for (int unsigned i = 0; i < NUM_STAGES; i++) begin
         rd          = rdAddress_Stage[i*ADDR_W +: ADDR_W];
         match_rs[i] = regWrite_Stage[i] && (rd != '0) && (rd == rsAddress_IfId) && usesRs_IfId;
         match_rt[i] = regWrite_Stage[i] && (rd != '0) && (rd == rtAddress_IfId) && usesRt_IfId;
         // Youngest conflicting stage dictates how long the stall lasts.
         if (!found && (match_rs[i] || match_rt[i])) begin
            hazardStage[i] = 1'b1;
            found          = 1'b1;
         end
      end
      hazardRs = |match_rs;
      hazardRt = |match_rt;
      stall    = instrValid_IfId && (hazardRs || hazardRt) && !flush;
      bubble   = stall;
   end

   always_comb begin
      episode_inc   = (episode_cnt_q == 8'hFF) ? episode_cnt_q : episode_cnt_q + 8'd1;
      state_d       = RUN;
      episode_cnt_d = '0;
      timeout_err_d = timeout_err_q;
      if (stall) begin
         state_d       = STALL;
         episode_cnt_d = episode_inc;
         // Watchdog is report-only; the stall itself is never cut short.
         if (32'(episode_inc) >= MAX_STALL) timeout_err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= RUN;
         episode_cnt_q <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         episode_cnt_q <= episode_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign stallActive = (state_q == STALL);
   assign timeoutErr  = timeout_err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
   logic [CNT_W-1:0] hazard_events_q, hazard_events_d;

   always_comb begin
      stall_cycles_d  = stall_cycles_q;
      hazard_events_d = hazard_events_q;
      if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
      if (stall && (state_q == RUN) && (hazard_events_q != '1))
         hazard_events_d = hazard_events_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles_q  <= '0;
         hazard_events_q <= '0;
      end else begin
         stall_cycles_q  <= stall_cycles_d;
         hazard_events_q <= hazard_events_d;
      end
   end

   assign stallCycles  = stall_cycles_q;
   assign hazardEvents = hazard_events_q;
`else
   assign stallCycles  = '0;
   assign hazardEvents = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Scoreboard bench for hazard_stall_controller (NUM_STAGES=3, MAX_STALL=4).
module tb_hazard_stall_controller;

   localparam int unsigned ADDR_W = 5;
   localparam int unsigned NS     = 3;
   localparam int unsigned CNT_W  = 16;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              valid, uses_rs, uses_rt, flush;
   logic [ADDR_W-1:0] rs, rt;
   logic [NS-1:0]     we;
   logic [ADDR_W-1:0] rd0, rd1, rd2;
   logic              stall, bubble, hz_rs, hz_rt, stall_active, timeout_err;
   logic [NS-1:0]     hz_stage;
   logic [CNT_W-1:0]  stall_cycles, hazard_events;

   hazard_stall_controller #(.ADDR_W(ADDR_W), .NUM_STAGES(NS), .MAX_STALL(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset_n(reset_n), .instrValid_IfId(valid), .usesRs_IfId(uses_rs),
      .usesRt_IfId(uses_rt), .rsAddress_IfId(rs), .rtAddress_IfId(rt),
      .regWrite_Stage(we), .rdAddress_Stage({rd2, rd1, rd0}), .flush(flush),
      .stall(stall), .bubble(bubble), .hazardRs(hz_rs), .hazardRt(hz_rt),
      .hazardStage(hz_stage), .stallActive(stall_active), .timeoutErr(timeout_err),
      .stallCycles(stall_cycles), .hazardEvents(hazard_events));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [40:0] vec;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [CNT_W-1:0] pc(input int v);
`ifdef HAZARD_PERF_CNT_EN
      return CNT_W'(v);
`else
      return '0 + CNT_W'(v - v);
`endif
   endfunction

   task automatic exp(input string name, input logic st, input logic hrs, input logic hrt,
                      input logic [2:0] stg, input logic act, input logic tmo,
                      input int cyc, input int ev);
      exp_t e;
      e.name = name;
      e.vec  = {st, st, hrs, hrt, stg, act, tmo, pc(cyc), pc(ev)};
      q.push_back(e);
   endtask

   task automatic drive(input logic v, input logic urs, input logic urt, input logic [4:0] a_rs,
                        input logic [4:0] a_rt, input logic [2:0] w, input logic [4:0] d0,
                        input logic [4:0] d1, input logic [4:0] d2, input logic fl);
      valid = v; uses_rs = urs; uses_rt = urt; rs = a_rs; rt = a_rt;
      we = w; rd0 = d0; rd1 = d1; rd2 = d2; flush = fl;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every falling edge, compare all queued expectations against the DUT.
   always @(negedge clk) begin
      logic [40:0] act;
      exp_t        e;
      while (q.size() > 0) begin
         e   = q.pop_front();
         act = {stall, bubble, hz_rs, hz_rt, hz_stage, stall_active, timeout_err,
                stall_cycles, hazard_events};
         total++;
         if (act !== e.vec) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", e.name, act, e.vec);
         end
      end
   end

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 0);
      tick(); tick();
      exp("reset", 0, 0, 0, 3'b000, 0, 0, 0, 0);
      tick();
      reset_n = 1'b1;

      // register 0, usesRs gating, write-enable gating, invalid instruction
      drive(1, 1, 0, 0, 0, 3'b001, 0, 0, 0, 0);  exp("r0",       0, 0, 0, 3'b000, 0, 0, 0, 0); tick();
      drive(1, 0, 0, 3, 0, 3'b001, 3, 0, 0, 0);  exp("no_uses",  0, 0, 0, 3'b000, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 3, 0, 3'b000, 3, 0, 0, 0);  exp("no_we",    0, 0, 0, 3'b000, 0, 0, 0, 0); tick();
      drive(0, 1, 0, 3, 0, 3'b001, 3, 0, 0, 0);  exp("invalid",  0, 1, 0, 3'b001, 0, 0, 0, 0); tick();

      // stage-2 rs match: one stall cycle
      drive(1, 1, 0, 5, 0, 3'b100, 0, 0, 5, 0);  exp("c1_hz",    1, 1, 0, 3'b100, 0, 0, 0, 0); tick();
      drive(1, 1, 0, 5, 0, 3'b000, 0, 0, 0, 0);  exp("c1_clr",   0, 0, 0, 3'b000, 1, 0, 1, 1); tick();
      exp("c1_run", 0, 0, 0, 3'b000, 0, 0, 1, 1); tick();

      // rt=7 in stages 0 and 2: three stall cycles as the writer advances
      drive(1, 0, 1, 0, 7, 3'b101, 7, 0, 7, 0);  exp("c3_s0",    1, 0, 1, 3'b001, 0, 0, 1, 1); tick();
      drive(1, 0, 1, 0, 7, 3'b010, 0, 7, 0, 0);  exp("c3_s1",    1, 0, 1, 3'b010, 1, 0, 2, 2); tick();
      drive(1, 0, 1, 0, 7, 3'b100, 0, 0, 7, 0);  exp("c3_s2",    1, 0, 1, 3'b100, 1, 0, 3, 2); tick();
      drive(1, 0, 1, 0, 7, 3'b000, 0, 0, 0, 0);  exp("c3_clr",   0, 0, 0, 3'b000, 1, 0, 4, 2); tick();
      exp("c3_run", 0, 0, 0, 3'b000, 0, 0, 4, 2); tick();

      // flush in second cycle of a stall
      drive(1, 1, 0, 9, 0, 3'b001, 9, 0, 0, 0);  exp("c4_hz",    1, 1, 0, 3'b001, 0, 0, 4, 2); tick();
      drive(1, 1, 0, 9, 0, 3'b010, 0, 9, 0, 1);  exp("c4_flush", 0, 1, 0, 3'b010, 1, 0, 5, 3); tick();
      drive(1, 1, 0, 9, 0, 3'b000, 0, 0, 0, 0);  exp("c4_after", 0, 0, 0, 3'b000, 0, 0, 5, 3); tick();

      // hazard and flush together from RUN: nothing counted
      drive(1, 1, 0, 9, 0, 3'b001, 9, 0, 0, 1);  exp("hz_flush", 0, 1, 0, 3'b001, 0, 0, 5, 3); tick();
      drive(1, 1, 0, 9, 0, 3'b000, 0, 0, 0, 0);  exp("hf_after", 0, 0, 0, 3'b000, 0, 0, 5, 3); tick();

      // hazard held 6 cycles with MAX_STALL=4
      drive(1, 1, 0, 11, 0, 3'b001, 11, 0, 0, 0);
      exp("c5_1", 1, 1, 0, 3'b001, 0, 0, 5, 3);  tick();
      exp("c5_2", 1, 1, 0, 3'b001, 1, 0, 6, 4);  tick();
      exp("c5_3", 1, 1, 0, 3'b001, 1, 0, 7, 4);  tick();
      exp("c5_4", 1, 1, 0, 3'b001, 1, 0, 8, 4);  tick();
      exp("c5_5", 1, 1, 0, 3'b001, 1, 1, 9, 4);  tick();
      exp("c5_6", 1, 1, 0, 3'b001, 1, 1, 10, 4); tick();
      drive(1, 1, 0, 11, 0, 3'b000, 0, 0, 0, 0);
      exp("c5_clr",  0, 0, 0, 3'b000, 1, 1, 11, 4); tick();
      exp("c5_keep", 0, 0, 0, 3'b000, 0, 1, 11, 4); tick();

      // reset pulsed mid-stall
      drive(1, 1, 0, 11, 0, 3'b001, 11, 0, 0, 0);
      exp("c6_1", 1, 1, 0, 3'b001, 0, 1, 11, 4); tick();
      exp("c6_2", 1, 1, 0, 3'b001, 1, 1, 12, 5); tick();
      reset_n = 1'b0;
      exp("c6_rst",  1, 1, 0, 3'b001, 0, 0, 0, 0); tick();
      exp("c6_hold", 1, 1, 0, 3'b001, 0, 0, 0, 0); tick();
      reset_n = 1'b1;
      exp("c6_rel",  1, 1, 0, 3'b001, 0, 0, 0, 0); tick();
      exp("c6_re1",  1, 1, 0, 3'b001, 1, 0, 1, 1); tick();
      drive(1, 1, 0, 11, 0, 3'b000, 0, 0, 0, 0);
      exp("c6_clr",  0, 0, 0, 3'b000, 1, 0, 2, 1); tick();

      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         bad++;
         total++;
         $display("FAIL drain: got=%0d pending want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Parametrised stall controller for the in-order pipeline. It compares the IF/ID source registers against the destinations of NUM_STAGES downstream writer stages. On a RAW hazard it holds PC and IF/ID and injects bubbles into ID/EX. It tracks each stall episode with a state machine, flags episodes that exceed a watchdog limit, and optionally keeps performance counters.

## Interface
Parameters:
- ADDR_W, 5, register address width
- NUM_STAGES, 3, writer stages checked; index 0 = youngest (ID/EX), NUM_STAGES-1 = oldest (MEM/WB)
- MAX_STALL, 8, stall cycles per episode before timeout; range 1..255
- CNT_W, 16, performance counter width

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- instrValid_IfId  input  1  IF/ID holds a real instruction
- usesRs_IfId  input  1  instruction reads rs
- usesRt_IfId  input  1  instruction reads rt
- rsAddress_IfId  input  ADDR_W  source register rs
- rtAddress_IfId  input  ADDR_W  source register rt
- regWrite_Stage  input  NUM_STAGES  per-stage write enable
- rdAddress_Stage  input  NUM_STAGES*ADDR_W  per-stage destination; stage i occupies bits [i*ADDR_W +: ADDR_W]
- flush  input  1  branch/exception flush; aborts any stall
- stall  output  1  hold PC and IF/ID (combinational)
- bubble  output  1  load NOP into ID/EX (combinational, equals stall)
- hazardRs  output  1  rs conflict detected this cycle
- hazardRt  output  1  rt conflict detected this cycle
- hazardStage  output  NUM_STAGES  one-hot of the youngest conflicting stage; 0 if none
- stallActive  output  1  registered: FSM in STALL
- timeoutErr  output  1  sticky watchdog flag
- stallCycles  output  CNT_W  total stalled cycles (macro only)
- hazardEvents  output  CNT_W  stall episodes started (macro only)

## Operation
- Stage i matches rs when all of these hold: regWrite_Stage[i], rd_i != 0, rd_i == rsAddress_IfId, usesRs_IfId. The rt match is the same with rt.
- hazardRs = OR of rs matches over all stages. hazardRt = OR of rt matches.
- hazardStage = lowest index with any match, one-hot.
- hz = instrValid_IfId & (hazardRs | hazardRt).
- stall = bubble = hz & ~flush. flush always wins.
- FSM, two states:
  - RUN → STALL when stall=1.
  - STALL → STALL while stall=1, with the episode counter incrementing.
  - STALL → RUN when stall=0, whether from hazard clear or flush. The episode counter clears on this transition.
- Watchdog:
  - If the episode counter reaches MAX_STALL while stall=1, timeoutErr sets.
  - timeoutErr stays set until reset.
  - Stall behaviour is unaffected by the watchdog; it reports only.
- Episode counter is 8 bits and saturates at 255.

## Timing
- Detection, stall and bubble are zero-latency: a change on any input is reflected in the same cycle.
- stallActive, timeoutErr and the counters update on the rising edge after the condition.
- A hazard on stage NUM_STAGES-1 alone stalls exactly 1 cycle. The general rule: stall length = NUM_STAGES - youngest matching index, assuming the pipeline advances one stage per cycle.
- Reset values: stallActive=0, timeoutErr=0, episode counter=0, stallCycles=0, hazardEvents=0, FSM=RUN.
- Combinational outputs follow their inputs even while reset_n=0.
- Reset asserted mid-stall returns the FSM to RUN at once and clears the episode counter.
- Counters saturate at all-ones and do not wrap.
- Simultaneous hazard and flush: stall=0, FSM goes to RUN, no event is counted.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stallCycles increments on every cycle with stall=1.
  - hazardEvents increments on every RUN→STALL transition.
- HAZARD_PERF_CNT_EN undefined:
  - Counter logic is removed.
  - stallCycles and hazardEvents are tied to 0.

## Test plan
- Case 1, stage-2 match on rs:
  - Stimulus: regWrite_Stage=3'b100, rd2=5, rs=5, usesRs=1, valid=1; drive the pipeline to advance.
  - Response: stall=1 for 1 cycle, hazardStage=3'b100, hazardRs=1, hazardEvents=1.
- Case 2, register 0:
  - Stimulus: rd0=0, regWrite_Stage[0]=1, rs=0.
  - Response: hazardRs=0, stall=0.
- Case 3, match on both stages 0 and 2 (rt=7 in both):
  - Response: hazardStage=3'b001, hazardRt=1, stall holds 3 cycles, stallCycles=3.
- Case 4, flush in cycle 2 of a stall:
  - Response: stall=0 in that same cycle, stallActive=0 the next cycle, stallCycles=1.
- Case 5, MAX_STALL=4 with a hazard held for 6 cycles:
  - Response: timeoutErr=1 after the 4th stalled edge; it stays 1 after the hazard clears and returns to 0 only on reset_n=0.
- Case 6, reset_n pulsed low mid-stall:
  - Response: stallActive and timeoutErr go to 0 without waiting for a clock edge; counters return to 0.
